// File: rtl/mem_bus_bridge.sv
// ============================================================================
// Module   : mem_bus_bridge
// Brief    : Single-outstanding bridge from the vector-core memory port to the
//            storage controller, with read timeout and optional byte-merge
//            writes enabled by the MEM_BUS_BRIDGE_RMW_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] SRAM_LIMIT     = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    output logic        mem_gnt_o,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o,
    output logic        sc_memory_access,
    output logic        sc_memory_is_writing,
    output logic [31:0] sc_addr,
    output logic [31:0] sc_d_in,
    output logic [3:0]  sc_mem_be,
    input  logic [31:0] sc_d_out,
    input  logic        sc_out_valid
);

    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        RD_WAIT = 3'd2,
        RESP    = 3'd5
`ifdef MEM_BUS_BRIDGE_RMW_EN
        ,
        RMW_WAIT = 3'd3,
        WR_ISSUE = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      sc_addr_q, sc_addr_d;
    logic [31:0]      sc_din_q, sc_din_d;
    logic [3:0]       sc_be_q, sc_be_d;
    logic             sc_we_q, sc_we_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
`ifdef MEM_BUS_BRIDGE_RMW_EN
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      merged;
`endif

    logic xfer;
    logic bad_req;
    logic full_wr;

    assign mem_gnt_o = (state_q == IDLE) && !rst;
    assign xfer      = mem_req_i && mem_gnt_o;
    assign full_wr   = mem_we_i && (mem_be_i == 4'hF);

    // Requests rejected without touching the storage controller.
    always_comb begin
        bad_req = (mem_addr_i[1:0] != 2'b00) ||
                  (mem_we_i && ((mem_addr_i >= SRAM_LIMIT) || (mem_be_i == 4'h0)));
`ifndef MEM_BUS_BRIDGE_RMW_EN
        bad_req = bad_req || (mem_we_i && (mem_be_i != 4'hF));
`endif
    end

`ifdef MEM_BUS_BRIDGE_RMW_EN
    always_comb begin
        merged = sc_d_out;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sc_addr_d = sc_addr_q;
        sc_din_d  = sc_din_q;
        sc_be_d   = sc_be_q;
        sc_we_d   = sc_we_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef MEM_BUS_BRIDGE_RMW_EN
        be_d      = be_q;
        wdata_d   = wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    we_d = mem_we_i;
`ifdef MEM_BUS_BRIDGE_RMW_EN
                    be_d    = mem_be_i;
                    wdata_d = mem_wdata_i;
`endif
                    if (bad_req) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else begin
                        // Partial writes start with a full-word read of the target.
                        sc_addr_d = mem_addr_i;
                        sc_we_d   = full_wr;
                        sc_be_d   = (mem_we_i && !full_wr) ? 4'hF : mem_be_i;
                        sc_din_d  = full_wr ? mem_wdata_i : 32'h0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (!we_q) begin
                    state_d = RD_WAIT;
`ifdef MEM_BUS_BRIDGE_RMW_EN
                end else if (!sc_we_q) begin
                    state_d = RMW_WAIT;
`endif
                end else begin
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end
            end
            RD_WAIT: begin
                if (sc_out_valid) begin
                    rdata_d = sc_d_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef MEM_BUS_BRIDGE_RMW_EN
            RMW_WAIT: begin
                if (sc_out_valid) begin
                    sc_din_d = merged;
                    sc_we_d  = 1'b1;
                    sc_be_d  = 4'hF;
                    state_d  = WR_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_ISSUE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = RESP;
            end
`endif
            RESP: begin
                // Clearing here keeps every downstream/response output at 0 in IDLE.
                state_d   = IDLE;
                cnt_d     = '0;
                we_d      = 1'b0;
                sc_addr_d = 32'h0;
                sc_din_d  = 32'h0;
                sc_be_d   = 4'h0;
                sc_we_d   = 1'b0;
                rdata_d   = 32'h0;
                err_d     = 1'b0;
`ifdef MEM_BUS_BRIDGE_RMW_EN
                be_d      = 4'h0;
                wdata_d   = 32'h0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sc_addr_q <= 32'h0;
            sc_din_q  <= 32'h0;
            sc_be_q   <= 4'h0;
            sc_we_q   <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
`ifdef MEM_BUS_BRIDGE_RMW_EN
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sc_addr_q <= sc_addr_d;
            sc_din_q  <= sc_din_d;
            sc_be_q   <= sc_be_d;
            sc_we_q   <= sc_we_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef MEM_BUS_BRIDGE_RMW_EN
            be_q      <= be_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

`ifdef MEM_BUS_BRIDGE_RMW_EN
    assign sc_memory_access = (state_q == ISSUE) || (state_q == WR_ISSUE);
`else
    assign sc_memory_access = (state_q == ISSUE);
`endif
    assign sc_memory_is_writing = sc_we_q;
    assign sc_addr              = sc_addr_q;
    assign sc_d_in              = sc_din_q;
    assign sc_mem_be            = sc_be_q;
    assign mem_rvalid_o         = (state_q == RESP);
    assign mem_rdata_o          = rdata_q;
    assign mem_err_o            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
// ============================================================================
// Module   : tb_mem_bus_bridge
// Brief    : Directed self-checking bench for mem_bus_bridge (TIMEOUT_CYCLES=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic        mem_gnt_o;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic        mem_rvalid_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;
    logic        sc_memory_access;
    logic        sc_memory_is_writing;
    logic [31:0] sc_addr;
    logic [31:0] sc_d_in;
    logic [3:0]  sc_mem_be;
    logic [31:0] sc_d_out;
    logic        sc_out_valid;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_rv   = 0;

    always #5 clk = ~clk;

    mem_bus_bridge #(
        .TIMEOUT_CYCLES(8),
        .SRAM_LIMIT    (32'h0000_2000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_req_i           (mem_req_i),
        .mem_gnt_o           (mem_gnt_o),
        .mem_addr_i          (mem_addr_i),
        .mem_we_i            (mem_we_i),
        .mem_be_i            (mem_be_i),
        .mem_wdata_i         (mem_wdata_i),
        .mem_rvalid_o        (mem_rvalid_o),
        .mem_rdata_o         (mem_rdata_o),
        .mem_err_o           (mem_err_o),
        .sc_memory_access    (sc_memory_access),
        .sc_memory_is_writing(sc_memory_is_writing),
        .sc_addr             (sc_addr),
        .sc_d_in             (sc_d_in),
        .sc_mem_be           (sc_mem_be),
        .sc_d_out            (sc_d_out),
        .sc_out_valid        (sc_out_valid)
    );

    // Pulse counters and the rvalid/gnt exclusivity check, sampled after the edge settles.
    always @(posedge clk) begin
        #2;
        if (sc_memory_access) n_acc++;
        if (mem_rvalid_o) n_rv++;
        checks++;
        if (mem_rvalid_o && mem_gnt_o) begin
            errors++;
            $display("FAIL rvalid_with_gnt: rvalid=%0b gnt=%0b required not both 1", mem_rvalid_o, mem_gnt_o);
        end
    end

    // Returns at the negedge of the first cycle after the transfer edge.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        checks++;
        if (mem_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL gnt_before_xfer: got %0b required 1", mem_gnt_o);
        end
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_be_i    = be;
        mem_wdata_i = wd;
        @(negedge clk);
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h0;
        mem_be_i    = 4'h0;
        mem_wdata_i = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %0b required 0", mem_gnt_o);
        end
        checks++;
        if ({mem_rvalid_o, mem_err_o, sc_memory_access, sc_memory_is_writing} !== 4'b0000 ||
            mem_rdata_o !== 32'h0 || sc_addr !== 32'h0 || sc_d_in !== 32'h0 || sc_mem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%0b err=%0b acc=%0b wr=%0b rdata=%h addr=%h din=%h be=%h required all 0",
                     mem_rvalid_o, mem_err_o, sc_memory_access, sc_memory_is_writing, mem_rdata_o, sc_addr, sc_d_in, sc_mem_be);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_gnt: got %0b required 1", mem_gnt_o);
        end
    endtask

    task automatic test_read;
        int a0, r0;
        a0 = n_acc; r0 = n_rv;
        xfer(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        checks++;
        if (sc_memory_access !== 1'b1 || sc_memory_is_writing !== 1'b0 || sc_addr !== 32'h100) begin
            errors++;
            $display("FAIL read_issue: acc=%0b wr=%0b addr=%h required 1 0 00000100", sc_memory_access, sc_memory_is_writing, sc_addr);
        end
        // Stray data during ISSUE must be ignored.
        sc_out_valid = 1'b1; sc_d_out = 32'hBAD0_BAD0;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (sc_memory_access !== 1'b0 || mem_rvalid_o !== 1'b0 || sc_addr !== 32'h100) begin
            errors++;
            $display("FAIL read_wait1: acc=%0b rv=%0b addr=%h required 0 0 00000100", sc_memory_access, mem_rvalid_o, sc_addr);
        end
        @(negedge clk);
        sc_out_valid = 1'b1; sc_d_out = 32'hDEAD_BEEF;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 32'hDEAD_BEEF || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL read_resp: rv=%0b rdata=%h err=%0b required 1 deadbeef 0", mem_rvalid_o, mem_rdata_o, mem_err_o);
        end
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b0 || mem_gnt_o !== 1'b1 || sc_addr !== 32'h0 || (n_acc - a0) !== 1 || (n_rv - r0) !== 1) begin
            errors++;
            $display("FAIL read_done: rv=%0b gnt=%0b addr=%h acc=%0d rvs=%0d required 0 1 0 1 1",
                     mem_rvalid_o, mem_gnt_o, sc_addr, n_acc - a0, n_rv - r0);
        end
    endtask

    task automatic test_write;
        int a0;
        a0 = n_acc;
        xfer(1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678);
        checks++;
        if (sc_memory_access !== 1'b1 || sc_memory_is_writing !== 1'b1 || sc_d_in !== 32'h1234_5678 ||
            sc_mem_be !== 4'hF || sc_addr !== 32'h40) begin
            errors++;
            $display("FAIL write_issue: acc=%0b wr=%0b din=%h be=%h addr=%h required 1 1 12345678 f 00000040",
                     sc_memory_access, sc_memory_is_writing, sc_d_in, sc_mem_be, sc_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b0 || mem_rdata_o !== 32'h0 || sc_memory_access !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: rv=%0b err=%0b rdata=%h acc=%0b required 1 0 0 0",
                     mem_rvalid_o, mem_err_o, mem_rdata_o, sc_memory_access);
        end
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b0 || mem_gnt_o !== 1'b1 || (n_acc - a0) !== 1) begin
            errors++;
            $display("FAIL write_done: rv=%0b gnt=%0b acc=%0d required 0 1 1", mem_rvalid_o, mem_gnt_o, n_acc - a0);
        end
    endtask

    task automatic test_errors;
        logic        we_t   [4];
        logic [31:0] addr_t [4];
        logic [3:0]  be_t   [4];
        int a0, n;
        we_t[0] = 1'b1; addr_t[0] = 32'h0000_2000; be_t[0] = 4'hF;
        we_t[1] = 1'b0; addr_t[1] = 32'h0000_0102; be_t[1] = 4'hF;
        we_t[2] = 1'b1; addr_t[2] = 32'h0000_0040; be_t[2] = 4'h0;
        we_t[3] = 1'b1; addr_t[3] = 32'h0000_0041; be_t[3] = 4'hF;
        n = 4;
        for (int i = 0; i < n; i++) begin
            a0 = n_acc;
            xfer(we_t[i], addr_t[i], be_t[i], 32'hFFFF_FFFF);
            checks++;
            if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b1 || mem_rdata_o !== 32'h0 || sc_memory_access !== 1'b0) begin
                errors++;
                $display("FAIL err_resp[%0d]: rv=%0b err=%0b rdata=%h acc=%0b required 1 1 0 0",
                         i, mem_rvalid_o, mem_err_o, mem_rdata_o, sc_memory_access);
            end
            @(negedge clk);
            checks++;
            if (mem_rvalid_o !== 1'b0 || mem_gnt_o !== 1'b1 || (n_acc - a0) !== 0) begin
                errors++;
                $display("FAIL err_done[%0d]: rv=%0b gnt=%0b acc=%0d required 0 1 0", i, mem_rvalid_o, mem_gnt_o, n_acc - a0);
            end
        end
        // Last word inside the writable window is accepted.
        xfer(1'b1, 32'h0000_1FFC, 4'hF, 32'hA5A5_5A5A);
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b0) begin
            errors++;
            $display("FAIL limit_edge_write: rv=%0b err=%0b required 1 0", mem_rvalid_o, mem_err_o);
        end
    endtask

    task automatic test_timeout;
        xfer(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (mem_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early[%0d]: rv=%0b required 0", k, mem_rvalid_o);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b1 || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: rv=%0b err=%0b rdata=%h required 1 1 0", mem_rvalid_o, mem_err_o, mem_rdata_o);
        end
        @(negedge clk);
        checks++;
        if (mem_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_regrant: gnt=%0b required 1", mem_gnt_o);
        end
        // Data arriving in the final wait cycle wins over the timeout.
        xfer(1'b0, 32'h0000_0204, 4'hF, 32'h0);
        repeat (8) @(negedge clk);
        sc_out_valid = 1'b1; sc_d_out = 32'hCAFE_F00D;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b0 || mem_rdata_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL data_wins: rv=%0b err=%0b rdata=%h required 1 0 cafef00d", mem_rvalid_o, mem_err_o, mem_rdata_o);
        end
    endtask

    task automatic test_partial_write;
        int a0;
        a0 = n_acc;
        xfer(1'b1, 32'h0000_0080, 4'b0101, 32'h1122_3344);
`ifdef MEM_BUS_BRIDGE_RMW_EN
        checks++;
        if (sc_memory_access !== 1'b1 || sc_memory_is_writing !== 1'b0) begin
            errors++;
            $display("FAIL rmw_read_issue: acc=%0b wr=%0b required 1 0", sc_memory_access, sc_memory_is_writing);
        end
        @(negedge clk);
        sc_out_valid = 1'b1; sc_d_out = 32'hAABB_CCDD;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (sc_memory_access !== 1'b1 || sc_memory_is_writing !== 1'b1 || sc_d_in !== 32'hAA22_CC44 || sc_mem_be !== 4'hF) begin
            errors++;
            $display("FAIL rmw_write_issue: acc=%0b wr=%0b din=%h be=%h required 1 1 aa22cc44 f",
                     sc_memory_access, sc_memory_is_writing, sc_d_in, sc_mem_be);
        end
        @(negedge clk);
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b0 || (n_acc - a0) !== 2) begin
            errors++;
            $display("FAIL rmw_resp: rv=%0b err=%0b acc=%0d required 1 0 2", mem_rvalid_o, mem_err_o, n_acc - a0);
        end
`else
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_err_o !== 1'b1 || sc_memory_access !== 1'b0) begin
            errors++;
            $display("FAIL partial_reject: rv=%0b err=%0b acc=%0b required 1 1 0", mem_rvalid_o, mem_err_o, sc_memory_access);
        end
        @(negedge clk);
        checks++;
        if ((n_acc - a0) !== 0) begin
            errors++;
            $display("FAIL partial_no_access: acc=%0d required 0", n_acc - a0);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int a0, r0;
        a0 = n_acc; r0 = n_rv;
        xfer(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_gnt_o !== 1'b0 || mem_rvalid_o !== 1'b0 || sc_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_state: gnt=%0b rv=%0b addr=%h required 0 0 0", mem_gnt_o, mem_rvalid_o, sc_addr);
        end
        rst = 1'b0;
        sc_out_valid = 1'b1; sc_d_out = 32'h5555_5555;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (mem_gnt_o !== 1'b1 || mem_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_regrant: gnt=%0b rv=%0b required 1 0", mem_gnt_o, mem_rvalid_o);
        end
        @(negedge clk);
        checks++;
        if ((n_rv - r0) !== 0 || (n_acc - a0) !== 1) begin
            errors++;
            $display("FAIL mid_reset_abandon: rvalids=%0d accesses=%0d required 0 1", n_rv - r0, n_acc - a0);
        end
    endtask

    task automatic test_back_to_back;
        xfer(1'b1, 32'h0000_0010, 4'hF, 32'h0BAD_CAFE);
        @(negedge clk);
        xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        checks++;
        if (sc_memory_access !== 1'b1 || sc_memory_is_writing !== 1'b0 || sc_d_in !== 32'h0) begin
            errors++;
            $display("FAIL b2b_read_issue: acc=%0b wr=%0b din=%h required 1 0 0", sc_memory_access, sc_memory_is_writing, sc_d_in);
        end
        @(negedge clk);
        sc_out_valid = 1'b1; sc_d_out = 32'h0BAD_CAFE;
        @(negedge clk);
        sc_out_valid = 1'b0; sc_d_out = 32'h0;
        checks++;
        if (mem_rvalid_o !== 1'b1 || mem_rdata_o !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL b2b_read_resp: rv=%0b rdata=%h required 1 0badcafe", mem_rvalid_o, mem_rdata_o);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_req_i = 1'b0; mem_addr_i = 32'h0; mem_we_i = 1'b0;
        mem_be_i = 4'h0; mem_wdata_i = 32'h0; sc_d_out = 32'h0; sc_out_valid = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_errors;
        test_timeout;
        test_partial_write;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1024, cycles to wait for read data before an error response.
REQ-002 SHALL provide parameter SRAM_LIMIT, default 32'h0000_2000, first address outside the writable SRAM window.
REQ-003 SHALL provide port clk  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL provide port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL provide ports mem_req_i in 1, mem_gnt_o out 1, mem_addr_i in 32, mem_we_i in 1, mem_be_i in 4, mem_wdata_i in 32: vector-core request channel.
REQ-006 SHALL provide ports mem_rvalid_o out 1, mem_rdata_o out 32, mem_err_o out 1: vector-core response channel.
REQ-007 SHALL provide ports sc_memory_access out 1, sc_memory_is_writing out 1, sc_addr out 32, sc_d_in out 32, sc_mem_be out 4: storage-controller request.
REQ-008 SHALL provide ports sc_d_out in 32 and sc_out_valid in 1: storage-controller read return.

Function
REQ-009 SHALL implement states IDLE, ISSUE, RD_WAIT, RMW_WAIT, WR_ISSUE, RESP.
REQ-010 mem_gnt_o SHALL equal (state==IDLE && !rst), combinationally; a transfer occurs on mem_req_i && mem_gnt_o.
REQ-011 On transfer, addr, we, be, wdata SHALL be latched; the request port is ignored until return to IDLE.
REQ-012 Latched addr[1:0]!=0, or write with addr>=SRAM_LIMIT, or write with be==0 SHALL go to RESP with err=1, with no downstream access.
REQ-013 Otherwise, the next cycle (ISSUE) SHALL pulse sc_memory_access for exactly one cycle.
REQ-014 sc_addr, sc_d_in, sc_mem_be, sc_memory_is_writing SHALL be held stable from ISSUE until the state returns to IDLE; they SHALL be 0 in IDLE.
REQ-015 Read: ISSUE->RD_WAIT; sc_out_valid high in RD_WAIT SHALL capture sc_d_out and go to RESP; sc_out_valid outside RD_WAIT/RMW_WAIT SHALL be ignored.
REQ-016 Full write (be==4'hF): ISSUE with is_writing=1, then RESP with err=0; the bridge does not wait for a downstream acknowledge.
REQ-017 RESP SHALL assert mem_rvalid_o for exactly one cycle with mem_rdata_o (captured data for reads, 0 for writes and errors) and mem_err_o, then return to IDLE.
REQ-018 Read-to-response latency SHALL be the sc_out_valid cycle +1; minimum transfer-to-rvalid is 3 cycles for reads and 2 cycles for full writes.
REQ-019 A wait counter SHALL clear at ISSUE and increment each cycle in RD_WAIT/RMW_WAIT; when it reaches TIMEOUT_CYCLES without sc_out_valid, the bridge SHALL go to RESP with err=1 and rdata=0.
REQ-020 sc_out_valid in the same cycle as the counter reaching TIMEOUT_CYCLES SHALL count as success (data wins).
REQ-021 mem_rvalid_o SHALL never be asserted in the same cycle as mem_gnt_o; one request outstanding maximum.

Reset
REQ-022 With rst high at a clock edge, state SHALL become IDLE and the counter and all latches SHALL clear; all outputs SHALL be 0.
REQ-023 Reset mid-transaction SHALL abandon it: no mem_rvalid_o and no further sc_memory_access for that request.
REQ-024 mem_gnt_o SHALL be 0 while rst is high.

Configuration
REQ-025 Macro MEM_BUS_BRIDGE_RMW_EN defined: partial write (be!=0, be!=4'hF) SHALL issue a read (ISSUE, sc_memory_is_writing=0), wait in RMW_WAIT, merge wdata bytes where be=1 into the returned word, then pulse sc_memory_access once in WR_ISSUE with is_writing=1, sc_mem_be=4'hF, then RESP err=0.
REQ-026 The RMW_WAIT timeout SHALL follow REQ-019, with no write issued.
REQ-027 Macro undefined: partial write SHALL go to RESP with err=1 and no downstream access; state RMW_WAIT/WR_ISSUE logic SHALL be absent.

Verification
REQ-028 Read addr 0x100, sc_out_valid with 0xDEADBEEF 2 cycles after pulse -> one rvalid, rdata 0xDEADBEEF, err 0.
REQ-029 Write addr 0x40, be 4'hF, wdata 0x12345678 -> one sc_memory_access with is_writing=1 and d_in 0x12345678; rvalid err 0 two cycles after transfer.
REQ-030 Write addr 0x2000 or read addr 0x102 -> no sc_memory_access; rvalid err 1, rdata 0.
REQ-031 Read, sc_out_valid never asserted, TIMEOUT_CYCLES=8 -> rvalid err 1 exactly 8 cycles after entering RD_WAIT; next request granted the following cycle.
REQ-032 RMW_EN: word 0xAABBCCDD, write be 4'b0101 wdata 0x11223344 -> write pulse d_in 0xAA22CC44; without the macro -> err 1, no access.
REQ-033 rst pulsed in RD_WAIT, then sc_out_valid -> no rvalid; gnt high the cycle after rst falls.
